// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared FSM state type, requester count (N=8) and index width (IW=3)
package rr_arbiter8_pkg;
  localparam int N = 8;
  localparam int IW = 3;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: arbiter bus; req_b/done in (active-low requests, owner done), gnt_b/gnt_idx/gnt_valid/timeout out
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;
  logic [N-1:0] req_b;
  logic done;
  logic [N-1:0] gnt_b;
  logic [IW-1:0] gnt_idx;
  logic gnt_valid;
  logic timeout;
  modport master (output req_b, done, input gnt_b, gnt_idx, gnt_valid, timeout);
  modport slave (input req_b, done, output gnt_b, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter8_pick.sv
// rr_pick: round-robin winner search from ptr+1; in req_b[7:0] (active-low), ptr[2:0]; out idx[2:0], any
module rr_pick
  import rr_arbiter8_pkg::*;
(
  input  logic [N-1:0]  req_b,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] start, off;
  logic [N-1:0] rot;
  always_comb begin
    start = ptr + 1'b1;
    rot = N'({~req_b, ~req_b} >> start);
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    idx = off + start;
    any = ~&req_b;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold limit; ports clk, rst (async high), bus (rr_arbiter8_if.slave)
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input logic clk,
  input logic rst,
  rr_arbiter8_if.slave bus
);
  localparam logic [7:0] HM = 8'(HOLD_MAX);
  state_t state;
  logic [IW-1:0] ptr, idx, pick_idx;
  logic [7:0] cnt, cnt_nx;
  logic valid, timeout, any, lim, drop, fin;
  rr_pick u_pick (.req_b(bus.req_b), .ptr(ptr), .idx(pick_idx), .any(any));
  assign cnt_nx = (cnt == HM) ? cnt : cnt + 8'd1;
  assign lim = cnt_nx == HM;
  assign drop = bus.req_b[idx];
  assign fin = bus.done | drop | lim;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '1;
      cnt <= '0;
      idx <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (any) begin
          state <= GRANT;
          idx <= pick_idx;
          ptr <= pick_idx;
          valid <= 1'b1;
          cnt <= '0;
        end
        GRANT: begin
          cnt <= cnt_nx;
          if (fin) begin
            state <= RELEASE;
            idx <= '0;
            valid <= 1'b0;
            timeout <= lim & ~bus.done & ~drop;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.gnt_b = valid ? ~(N'(1) << idx) : '1;
  assign bus.gnt_idx = idx;
  assign bus.gnt_valid = valid;
  assign bus.timeout = timeout;
endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter HOLD_MAX, default 15: maximum consecutive cycles one grant SHALL be held before forced release (range 1..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_b  input  8  active-low request, bit i = requester i.
REQ-005 done  input  1  active-high pulse from the current owner ending its grant.
REQ-006 gnt_b  output  8  active-low one-hot grant; 8'hFF = no grant.
REQ-007 gnt_idx  output  3  binary index of the current owner; 0 when no grant.
REQ-008 gnt_valid  output  1  high exactly when one gnt_b bit is low.
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-released by the HOLD_MAX limit.

Function
REQ-010 FSM states SHALL be IDLE, GRANT and RELEASE.
REQ-011 IDLE: on a clock edge with any req_b bit low, the FSM SHALL go to GRANT; grant outputs appear the next cycle (1-cycle latency); with no request it SHALL stay in IDLE.
REQ-012 Winner selection SHALL be round-robin: search from index ptr+1 upward modulo 8; the first low req_b bit wins.
REQ-013 ptr SHALL be 3 bits, wrap 7->0, and SHALL load the winner index on entry to GRANT.
REQ-014 In GRANT, gnt_b SHALL be the active-low decode of gnt_idx and SHALL stay constant until the grant ends.
REQ-015 GRANT SHALL go to RELEASE on the first edge where done=1, the owner's req_b bit is high, or the hold counter reaches HOLD_MAX.
REQ-016 The hold counter SHALL clear on entry to GRANT, increment once per GRANT cycle, and saturate at HOLD_MAX.
REQ-017 timeout SHALL pulse in the RELEASE cycle only when the counter limit caused the exit and done was 0 with the owner's request still low.
REQ-018 If done and the HOLD_MAX limit occur on the same edge, done SHALL take priority and timeout SHALL stay 0.
REQ-019 RELEASE SHALL last exactly one cycle with gnt_b=8'hFF, gnt_valid=0 and gnt_idx=0, then go to IDLE (guaranteed dead cycle between owners).
REQ-020 done while in IDLE or RELEASE SHALL be ignored.
REQ-021 Requests changing in RELEASE SHALL NOT affect outputs; arbitration SHALL use req_b as sampled in IDLE only.
REQ-022 A lone requester SHALL be re-granted after each IDLE; an 8-way contention SHALL serve each index once per 8 grants.

Reset
REQ-023 While rst=1, outputs SHALL immediately take gnt_b=8'hFF, gnt_idx=0, gnt_valid=0 and timeout=0.
REQ-024 Reset SHALL set state=IDLE, ptr=7 so the first search starts at index 0, and hold counter=0.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant asynchronously with no RELEASE cycle.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE/GRANT/RELEASE), the requester count 8 and the index width 3.
REQ-027 The rotate, priority-encode and unrotate logic SHALL be one combinational sub-module, rr_pick, with inputs req_b[7:0] and ptr[2:0] and outputs idx[2:0] and any.
REQ-028 The grant decode SHALL be a function of gnt_idx and gnt_valid; it SHALL NOT be separately registered state.

Verification
REQ-029 Reset, then req_b=8'b1111_1011 -> gnt_b=8'b1111_1011 and gnt_idx=2 one cycle after IDLE samples it; done pulse -> one RELEASE cycle with gnt_b=8'hFF.
REQ-030 req_b=8'h00 held, done pulsed every grant -> gnt_idx sequence 0,1,2,...,7,0 with exactly one dead cycle between grants.
REQ-031 HOLD_MAX=4, req_b=8'b0111_1111 held and done never pulsed -> 4 grant cycles at idx 7, then timeout=1 for one cycle, then re-grant idx 7.
REQ-032 Owner idx 3 raises req_b[3] mid-grant -> RELEASE on the next edge, timeout=0.
REQ-033 rst asserted mid-GRANT, between clock edges -> gnt_b=8'hFF immediately; after release, req_b=8'h00 -> first grant idx 0.
REQ-034 done and the HOLD_MAX limit on the same edge -> RELEASE with timeout=0; done in IDLE -> no state change.
